// File: rtl/instruction_sequencer_pkg.sv
// Shared constants for the instruction sequencer:
// opcodes, FSM encodings and opcode classification.
package instruction_sequencer_pkg;

  localparam int SEQ_PC_WIDTH = 8;

  localparam int unsigned OPCODE_HALT  = 0;
  localparam int unsigned OPCODE_DRAW  = 1;
  localparam int unsigned OPCODE_MEMRD = 2;
  localparam int unsigned OPCODE_MEMWR = 3;
  localparam int unsigned OPCODE_JMP   = 4;
  localparam int unsigned OPCODE_BRZ   = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  typedef struct packed {
    logic halt;
    logic fwd;
    logic jmp;
    logic brz;
    logic nop;
  } op_class_t;

  // Exactly one class bit is set for any opcode.
  function automatic op_class_t classify(
    input logic [31:0] op
  );
    op_class_t c;
    c = '0;
    if (op == OPCODE_HALT) begin
      c.halt = 1'b1;
    end else if (op == OPCODE_DRAW ||
                 op == OPCODE_MEMRD ||
                 op == OPCODE_MEMWR) begin
      c.fwd = 1'b1;
    end else if (op == OPCODE_JMP) begin
      c.jmp = 1'b1;
    end else if (op == OPCODE_BRZ) begin
      c.brz = 1'b1;
    end else begin
      c.nop = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Program sequencer: fetches from a registered ROM,
// runs flow control locally, issues datapath ops.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int OP_W     = 4,
  parameter int RESULT_W = 16,
  parameter int PC_W     = SEQ_PC_WIDTH,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                go_i,
  output logic [PC_W-1:0]     prog_addr_o,
  input  logic [INSTR_W-1:0]  prog_data_i,
  output logic                dp_start_o,
  output logic [INSTR_W-1:0]  dp_instr_o,
  input  logic                dp_finished_i,
  input  logic [RESULT_W-1:0] dp_result_i,
  output logic                busy_o,
  output logic                halted_o,
  output logic                error_o,
  output logic [RESULT_W-1:0] last_result_o,
  output logic [PC_W-1:0]     pc_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [PC_W-1:0] PC_MAX = '1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic                fwait_q, fwait_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [RESULT_W-1:0] lres_q, lres_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [OP_W-1:0]     new_op;
  logic [OP_W-1:0]     held_op;
  logic [PC_W-1:0]     target;
  logic [PC_W-1:0]     pc_inc;
  logic                pc_ovf;
  logic                held_rd;
  op_class_t           cls;

  assign new_op  = prog_data_i[INSTR_W-1 -: OP_W];
  assign held_op = instr_q[INSTR_W-1 -: OP_W];
  assign target  = prog_data_i[PC_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_ovf  = (pc_q == PC_MAX);
  assign cls     = classify(32'(new_op));
  assign held_rd = (32'(held_op) == OPCODE_MEMRD);

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    fwait_d = fwait_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    lres_d  = lres_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (go_i) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          fwait_d = 1'b0;
        end
      end
      ST_FETCH: begin
        addr_d  = pc_q;
        fwait_d = 1'b1;
        if (fwait_q) begin
          fwait_d = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        unique case (1'b1)
          cls.halt: state_d = ST_HALTED;
          cls.fwd: begin
            instr_d = prog_data_i;
            state_d = ST_ISSUE;
          end
          cls.jmp: begin
            pc_d    = target;
            state_d = ST_FETCH;
          end
          cls.brz: begin
            if (lres_q == '0) begin
              pc_d    = target;
              state_d = ST_FETCH;
            end else if (pc_ovf) begin
              state_d = ST_ERROR;
            end else begin
              pc_d    = pc_inc;
              state_d = ST_FETCH;
            end
          end
          cls.nop: begin
            if (pc_ovf) begin
              state_d = ST_ERROR;
            end else begin
              pc_d    = pc_inc;
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_ERROR;
        endcase
      end
      ST_ISSUE: begin
        if (dp_finished_i) begin
          wd_d    = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dp_finished_i) begin
          if (held_rd) begin
            lres_d = dp_result_i;
          end
          if (pc_ovf) begin
            state_d = ST_ERROR;
          end else begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end else if (wd_q == WD_LIM) begin
          state_d = ST_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      fwait_q <= 1'b0;
      pc_q    <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      lres_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      fwait_q <= fwait_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      lres_q  <= lres_d;
      wd_q    <= wd_d;
    end
  end

  // The issue strobe fires in ISSUE on the cycle
  // the datapath reports idle, so it lasts 1 cycle.
  assign dp_start_o    = (state_q == ST_ISSUE)
                       && dp_finished_i;
  assign dp_instr_o    = instr_q;
  assign prog_addr_o   = addr_q;
  assign pc_o          = pc_q;
  assign last_result_o = lres_q;
  assign halted_o      = (state_q == ST_HALTED);
  assign error_o       = (state_q == ST_ERROR);
  assign busy_o        = (state_q == ST_FETCH)
                       || (state_q == ST_DECODE)
                       || (state_q == ST_ISSUE)
                       || (state_q == ST_ACK)
                       || (state_q == ST_WAIT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: ROM and datapath
// models plus a program-level reference interpreter.
module tb_instruction_sequencer;

  localparam int TO = 1023;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        dp_start;
  logic [31:0] dp_instr;
  logic        dp_finished;
  logic [15:0] dp_result;
  logic        busy;
  logic        halted;
  logic        error;
  logic [15:0] last_result;
  logic [7:0]  pc;

  instruction_sequencer #(
    .INSTR_W(32), .OP_W(4), .RESULT_W(16),
    .PC_W(8), .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .go_i(go),
    .prog_addr_o(prog_addr),
    .prog_data_i(prog_data),
    .dp_start_o(dp_start),
    .dp_instr_o(dp_instr),
    .dp_finished_i(dp_finished),
    .dp_result_i(dp_result),
    .busy_o(busy),
    .halted_o(halted),
    .error_o(error),
    .last_result_o(last_result),
    .pc_o(pc)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [256];

  always @(posedge clock) prog_data <= rom[prog_addr];

  int          dp_lat = 2;
  bit          dp_hang = 1'b0;
  logic [15:0] dp_ret = '0;
  int          dp_cnt;

  always @(posedge clock) begin
    if (!resetn) begin
      dp_finished <= 1'b1;
      dp_result   <= '0;
      dp_cnt      <= 0;
    end else if (dp_start) begin
      dp_finished <= 1'b0;
      dp_cnt      <= dp_lat;
    end else if (!dp_finished && !dp_hang) begin
      if (dp_cnt == 0) begin
        dp_finished <= 1'b1;
        dp_result   <= dp_ret;
      end else begin
        dp_cnt <= dp_cnt - 1;
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [31:0] exp_q [$];
  logic [15:0] m_lr = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endtask

  // Per-cycle compare against the interpreter's
  // expected issue stream and protocol rules.
  always @(negedge clock) begin
    total++;
    if (dp_start && !(dp_finished && busy)) begin
      bad++;
      $display("FAIL start_rule: start=%0b fin=%0b busy=%0b",
               dp_start, dp_finished, busy);
    end
    total++;
    if ((int'(busy) + int'(halted) + int'(error)) > 1) begin
      bad++;
      $display("FAIL status_excl: busy=%0b halted=%0b error=%0b",
               busy, halted, error);
    end
    if (dp_start) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue: got %0h want none", dp_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dp_instr !== e) begin
          bad++;
          $display("FAIL issue: got %0h want %0h",
                   dp_instr, e);
        end
      end
    end
  end

  // Interprets the ROM program as an ISA would.
  task automatic model_run(input logic [15:0] ret,
                           input bit hang,
                           output bit mh,
                           output bit me,
                           output logic [7:0] mp);
    int p;
    int steps;
    int op;
    bit adv;
    logic [31:0] w;
    p = 0;
    steps = 0;
    mh = 1'b0;
    me = 1'b0;
    while (!mh && !me && steps < 4000) begin
      w = rom[p];
      op = int'(w[31:28]);
      adv = 1'b0;
      steps++;
      case (op)
        0: mh = 1'b1;
        1, 2, 3: begin
          exp_q.push_back(w);
          if (hang) begin
            me = 1'b1;
          end else begin
            if (op == 2) m_lr = ret;
            adv = 1'b1;
          end
        end
        4: p = int'(w[7:0]);
        5: begin
          if (m_lr == 0) p = int'(w[7:0]);
          else adv = 1'b1;
        end
        default: adv = 1'b1;
      endcase
      if (adv) begin
        if (p == 255) me = 1'b1;
        else p++;
      end
    end
    mp = 8'(p);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic run(input string nm,
                     input logic [15:0] ret,
                     input bit hang,
                     input bit spam,
                     output int cyc,
                     output int scyc);
    bit mh;
    bit me;
    logic [7:0] mp;
    model_run(ret, hang, mh, me, mp);
    dp_ret = ret;
    dp_hang = hang;
    pulses = 0;
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = spam;
    cyc = 1;
    scyc = -1;
    chk({nm, "_start_pc"}, 32'(pc), 32'd0);
    chk({nm, "_start_busy"}, 32'(busy), 32'd1);
    while (!(halted || error) && cyc < 3000) begin
      if (dp_start && scyc < 0) scyc = cyc;
      @(negedge clock);
      cyc++;
    end
    go = 1'b0;
    chk({nm, "_bound"}, 32'(cyc < 3000), 32'd1);
    chk({nm, "_halted"}, 32'(halted), 32'(mh));
    chk({nm, "_error"}, 32'(error), 32'(me));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_pc"}, 32'(pc), 32'(mp));
    chk({nm, "_lres"}, 32'(last_result), 32'(m_lr));
    chk({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_addr"}, 32'(prog_addr), 32'd0);
    chk({nm, "_pc"}, 32'(pc), 32'd0);
    chk({nm, "_instr"}, dp_instr, 32'd0);
    chk({nm, "_lres"}, 32'(last_result), 32'd0);
    chk({nm, "_start"}, 32'(dp_start), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_halted"}, 32'(halted), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int cyc;
    int scyc;
    bit mh;
    bit me;
    logic [7:0] mp;
    rom_clear();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset("rst0");
    resetn = 1'b1;

    // HALT at 0: halted on the 4th cycle after go.
    run("halt", 16'd0, 1'b0, 1'b0, cyc, scyc);
    chk("halt_cycle", 32'(cyc), 32'd4);
    chk("halt_pulses", 32'(pulses), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);

    // MEMRD then HALT; datapath returns 15.
    rom_clear();
    rom[0] = {4'h2, 28'h5};
    run("memrd", 16'd15, 1'b0, 1'b0, cyc, scyc);
    chk("memrd_pulses", 32'(pulses), 32'd1);
    chk("memrd_lres", 32'(last_result), 32'd15);
    chk("memrd_issue_cyc", 32'(scyc), 32'd4);

    // JMP skips a DRAW; go held high while busy.
    rom_clear();
    rom[0] = {4'h3, 28'h123};
    rom[1] = {4'h4, 28'h3};
    rom[2] = {4'h1, 28'hAAA};
    rom[3] = {4'h1, 28'hBBB};
    run("jmp", 16'd99, 1'b0, 1'b1, cyc, scyc);
    chk("jmp_pulses", 32'(pulses), 32'd2);
    chk("jmp_pc", 32'(pc), 32'd4);
    chk("jmp_lres_kept", 32'(last_result), 32'd15);

    // BRZ taken on zero, falls through otherwise.
    rom_clear();
    rom[0] = {4'h2, 28'h0};
    rom[1] = {4'h5, 28'h4};
    run("brz0", 16'd0, 1'b0, 1'b0, cyc, scyc);
    chk("brz0_pc", 32'(pc), 32'd4);
    run("brz7", 16'd7, 1'b0, 1'b0, cyc, scyc);
    chk("brz7_pc", 32'(pc), 32'd2);
    chk("brz7_lres", 32'(last_result), 32'd7);

    // Watchdog: datapath never finishes.
    rom_clear();
    rom[0] = {4'h6, 28'h0};
    rom[1] = {4'h1, 28'h77};
    run("wdog", 16'd0, 1'b1, 1'b0, cyc, scyc);
    chk("wdog_issue_cyc", 32'(scyc), 32'd7);
    chk("wdog_err_cyc", 32'(cyc), 32'(scyc + TO + 3));
    chk("wdog_err_lit", 32'(cyc), 32'd1033);
    chk("wdog_pc", 32'(pc), 32'd1);
    dp_hang = 1'b0;
    cyc = 0;
    while (!dp_finished && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("wdog_dp_idle", 32'(dp_finished), 32'd1);
    run("wdog_go", 16'd0, 1'b0, 1'b0, cyc, scyc);
    chk("wdog_go_pc", 32'(pc), 32'd2);

    // PC increment past the top is an error.
    rom_clear();
    rom[0] = {4'h4, 28'hFF};
    rom[255] = {4'h7, 28'h0};
    run("ovf", 16'd0, 1'b0, 1'b0, cyc, scyc);
    chk("ovf_err", 32'(error), 32'd1);
    chk("ovf_pc", 32'(pc), 32'd255);

    // Reset while waiting on the datapath.
    rom_clear();
    rom[0] = {4'h2, 28'h9};
    model_run(16'd0, 1'b1, mh, me, mp);
    dp_hang = 1'b1;
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    cyc = 0;
    while (!dp_start && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk("rstw_issued", 32'(cyc < 50), 32'd1);
    repeat (3) @(negedge clock);
    chk("rstw_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk_reset("rstw");
    resetn = 1'b1;
    dp_hang = 1'b0;
    m_lr = '0;
    exp_q.delete();
    rom[0] = {4'h2, 28'h5};
    run("rstw_go", 16'd15, 1'b0, 1'b0, cyc, scyc);
    chk("rstw_go_lres", 32'(last_result), 32'd15);
    chk("rstw_go_pulses", 32'(pulses), 32'd1);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
